tpu_issue_queue: RTL

//  Multi-context instruction/thread-ID issue queue between the MPU request path and the Scalar Unit.
//  - Successor to the single instr/ID buffer pair: instr and thread-ID are stored together in one lock-step entry.
//  - NUM_CTX independent per-context FIFOs; each context holds one complete thread program.
//  - Round-robin grant selects one finished program at a time, which issues in order until drained.

---
 rtl/tpu_issue_queue_pkg.sv | 34 +++
 rtl/tpu_issue_queue_ctx_fifo.sv | 64 ++++++
 rtl/tpu_issue_queue.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tpu_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_issue_queue_pkg
// Purpose  : Shared types for the multi-context issue queue: context id,
//            per-context lifecycle state and the stored entry layout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tpu_issue_queue_pkg;

    localparam int DEF_NUM_CTX = 4;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_ID_W    = 8;

    typedef logic [$clog2(DEF_NUM_CTX)-1:0] ctx_id_t;

    // Per-context lifecycle: empty, collecting a program, program complete,
    // program issuing.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        RUN   = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ID_W-1:0]    id;
        logic                   last;
    } issue_entry_t;

endpackage
`default_nettype wire

// File: rtl/tpu_issue_queue_ctx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tpu_issue_queue_ctx_fifo
// Purpose  : Show-ahead FIFO holding one context's instruction/thread-ID
//            entries. The head entry is visible on dout without a pop.
// Ports    : clock, reset (async active-low)
//            push/din   - write an entry (ignored when full)
//            pop        - drop the head entry (ignored when empty)
//            dout       - head entry
//            count/full - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module tpu_issue_queue_ctx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 41
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally; count disambiguates full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by count alone.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/tpu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tpu_issue_queue
// Purpose  : Multi-context instruction/thread-ID issue queue. Each context
//            collects one complete program; a round-robin arbiter grants one
//            finished program at a time, which issues in order until drained.
// Ports    : clock, reset (async active-low)
//            I_Req/I_Ctx/I_Instr/I_ThreadID/I_Last - write side, O_Nack reject
//            I_En_Exe  - enables grant and issue
//            O_Valid/O_Instr/O_ThreadID/O_Ctx, I_Ready - issue handshake
//            O_Term    - pulse after the program's last entry is consumed
//            O_Busy    - per-context non-idle flags
// Revision : 1.0 - initial release
// ============================================================================
module tpu_issue_queue
    import tpu_issue_queue_pkg::*;
#(
    parameter int NUM_CTX = DEF_NUM_CTX,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       I_En_Exe,
    input  logic                       I_Req,
    input  logic [$clog2(NUM_CTX)-1:0] I_Ctx,
    input  logic [INSTR_W-1:0]         I_Instr,
    input  logic [ID_W-1:0]            I_ThreadID,
    input  logic                       I_Last,
    output logic                       O_Nack,
    output logic                       O_Valid,
    output logic [INSTR_W-1:0]         O_Instr,
    output logic [ID_W-1:0]            O_ThreadID,
    output logic [$clog2(NUM_CTX)-1:0] O_Ctx,
    input  logic                       I_Ready,
    output logic                       O_Term,
    output logic [NUM_CTX-1:0]         O_Busy
);

    localparam int CTX_W = $clog2(NUM_CTX);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ID_W-1:0]    id;
        logic               last;
    } entry_t;

    issue_state_t     state [NUM_CTX];
    logic [CTX_W-1:0] rr_ptr;
    logic [CTX_W-1:0] run_ctx;
    logic             term_q;

    logic [NUM_CTX-1:0] push;
    logic [NUM_CTX-1:0] pop;
    logic [NUM_CTX-1:0] full;
    logic [NUM_CTX-1:0] is_run;
    entry_t             head  [NUM_CTX];
    logic [CNT_W-1:0]   count [NUM_CTX];
    entry_t             wr_entry;

    logic             wr_ok;
    logic             any_run;
    logic             head_valid;
    logic             issue_fire;
    logic             last_pop;
    logic             grant_vld;
    logic             do_grant;
    logic [CTX_W-1:0] grant_ctx;
    logic [CTX_W-1:0] scan_idx;

    assign wr_entry = '{instr: I_Instr, id: I_ThreadID, last: I_Last};

    generate
        for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx
            tpu_issue_queue_ctx_fifo #(
                .DEPTH (DEPTH),
                .WIDTH ($bits(entry_t))
            ) u_fifo (
                .clock (clock),
                .reset (reset),
                .push  (push[i]),
                .pop   (pop[i]),
                .din   (wr_entry),
                .dout  (head[i]),
                .count (count[i]),
                .full  (full[i])
            );
            assign push[i]   = wr_ok && (I_Ctx == CTX_W'(i));
            assign pop[i]    = issue_fire && (run_ctx == CTX_W'(i));
            assign is_run[i] = (state[i] == RUN);
            assign O_Busy[i] = (state[i] != IDLE);
        end
    endgenerate

    // Writes only land in contexts still collecting a program.
    assign wr_ok  = I_Req && ((state[I_Ctx] == IDLE) || (state[I_Ctx] == LOAD))
                    && !full[I_Ctx];
    assign O_Nack = I_Req && !wr_ok;

    assign any_run    = |is_run;
    assign head_valid = I_En_Exe && is_run[run_ctx] && (count[run_ctx] != '0);
    assign issue_fire = head_valid && I_Ready;
    assign last_pop   = issue_fire && head[run_ctx].last;

    assign O_Valid    = head_valid;
    assign O_Instr    = head_valid ? head[run_ctx].instr : '0;
    assign O_ThreadID = head_valid ? head[run_ctx].id    : '0;
    assign O_Ctx      = run_ctx;
    assign O_Term     = term_q;

    // Scan downward so the READY context closest above rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_ctx = '0;
        scan_idx  = '0;
        for (int k = NUM_CTX - 1; k >= 0; k--) begin
            scan_idx = rr_ptr + CTX_W'(k);
            if (state[scan_idx] == READY) begin
                grant_vld = 1'b1;
                grant_ctx = scan_idx;
            end
        end
    end

    assign do_grant = grant_vld && !any_run && I_En_Exe;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CTX; i++) state[i] <= IDLE;
            rr_ptr  <= '0;
            run_ctx <= '0;
            term_q  <= 1'b0;
        end else begin
            term_q <= last_pop;
            for (int i = 0; i < NUM_CTX; i++) begin
                case (state[i])
                    IDLE:    if (push[i]) state[i] <= I_Last ? READY : LOAD;
                    LOAD:    if (push[i] && I_Last) state[i] <= READY;
                    READY:   if (do_grant && (grant_ctx == CTX_W'(i))) state[i] <= RUN;
                    RUN:     if (last_pop && (run_ctx == CTX_W'(i))) state[i] <= IDLE;
                    default: state[i] <= IDLE;
                endcase
            end
            if (do_grant) begin
                run_ctx <= grant_ctx;
                rr_ptr  <= grant_ctx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
